// File: rtl/l2_way_data_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// l2_way_data_array : NUM_WAYS x NUM_SETS line store, byte-write, write-first
// read of all ways, zero-fill sweep after reset.            Rev 1.0
// ----------------------------------------------------------------------------
module l2_way_data_array #(
   parameter  int S_OFFSET = 5,
   parameter  int S_INDEX  = 3,
   parameter  int NUM_WAYS = 4,
   localparam int S_WAY    = $clog2(NUM_WAYS),
   localparam int S_MASK   = 2**S_OFFSET,
   localparam int S_LINE   = 8*S_MASK,
   localparam int NUM_SETS = 2**S_INDEX
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       read,
   input  logic [S_MASK-1:0]          write_en,
   input  logic [S_WAY-1:0]           write_way,
   input  logic [S_INDEX-1:0]         index,
   input  logic [S_LINE-1:0]          datain,
   output logic [NUM_WAYS*S_LINE-1:0] dataout,
   output logic                       rdata_valid,
   output logic                       ready
);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t                      state_q,       state_d;
   logic [S_INDEX-1:0]          clr_idx_q,     clr_idx_d;
   logic                        ready_q,       ready_d;
   logic                        rdata_valid_q, rdata_valid_d;
   logic [NUM_WAYS*S_LINE-1:0]  dataout_q,     dataout_d;
   logic [S_LINE-1:0]           mem_q [NUM_SETS][NUM_WAYS];
   logic [S_LINE-1:0]           mem_d [NUM_SETS][NUM_WAYS];

   always_comb begin
      state_d       = state_q;
      clr_idx_d     = clr_idx_q;
      ready_d       = ready_q;
      rdata_valid_d = 1'b0;
      dataout_d     = dataout_q;
      mem_d         = mem_q;

      if (state_q == ST_CLEAR) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            mem_d[clr_idx_q][w] = '0;
         end
         clr_idx_d = clr_idx_q + S_INDEX'(1);
         if (clr_idx_q == '1) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
         end
      end else begin
         for (int b = 0; b < S_MASK; b++) begin
            if (write_en[b]) begin
               mem_d[index][write_way][8*b +: 8] = datain[8*b +: 8];
            end
         end
         // Read samples the post-write image, giving write-first on a same-index collision.
         if (read) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               dataout_d[w*S_LINE +: S_LINE] = mem_d[index][w];
            end
            rdata_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_CLEAR;
         clr_idx_q     <= '0;
         ready_q       <= 1'b0;
         rdata_valid_q <= 1'b0;
         dataout_q     <= '0;
      end else begin
         state_q       <= state_d;
         clr_idx_q     <= clr_idx_d;
         ready_q       <= ready_d;
         rdata_valid_q <= rdata_valid_d;
         dataout_q     <= dataout_d;
      end
      // Array is never bulk-cleared; a reset cycle only blocks that cycle's update.
      if (!rst) begin
         mem_q <= mem_d;
      end
   end

   assign dataout     = dataout_q;
   assign rdata_valid = rdata_valid_q;
   assign ready       = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_l2_way_data_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_l2_way_data_array : directed + random checks against a byte-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_l2_way_data_array;

   localparam int S_OFFSET = 5;
   localparam int S_INDEX  = 3;
   localparam int NUM_WAYS = 4;
   localparam int S_WAY    = 2;
   localparam int S_MASK   = 32;
   localparam int S_LINE   = 256;
   localparam int NUM_SETS = 8;
   localparam int DW       = NUM_WAYS*S_LINE;

   logic                clk = 1'b0;
   logic                rst;
   logic                read;
   logic [S_MASK-1:0]   write_en;
   logic [S_WAY-1:0]    write_way;
   logic [S_INDEX-1:0]  index;
   logic [S_LINE-1:0]   datain;
   logic [DW-1:0]       dataout;
   logic                rdata_valid;
   logic                ready;

   l2_way_data_array #(
      .S_OFFSET (S_OFFSET),
      .S_INDEX  (S_INDEX),
      .NUM_WAYS (NUM_WAYS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .read        (read),
      .write_en    (write_en),
      .write_way   (write_way),
      .index       (index),
      .datain      (datain),
      .dataout     (dataout),
      .rdata_valid (rdata_valid),
      .ready       (ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: bytes per set/way, a zero-fill counter, and the last read image.
   logic [7:0]    ref_mem [NUM_SETS][NUM_WAYS][S_MASK];
   logic          m_ready;
   logic          m_valid;
   int            m_sweep;
   logic [DW-1:0] m_dout;

   task automatic chk(input string tag, input logic [S_LINE-1:0] obs, input logic [S_LINE-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_ready = 1'b0;
         m_sweep = 0;
         m_valid = 1'b0;
         m_dout  = '0;
      end else if (!m_ready) begin
         for (int w = 0; w < NUM_WAYS; w++)
            for (int b = 0; b < S_MASK; b++)
               ref_mem[m_sweep][w][b] = 8'h00;
         m_sweep++;
         if (m_sweep == NUM_SETS) m_ready = 1'b1;
         m_valid = 1'b0;
      end else begin
         for (int b = 0; b < S_MASK; b++)
            if (write_en[b]) ref_mem[index][write_way][b] = datain[8*b +: 8];
         m_valid = read;
         if (read)
            for (int w = 0; w < NUM_WAYS; w++)
               for (int b = 0; b < S_MASK; b++)
                  m_dout[(w*S_MASK + b)*8 +: 8] = ref_mem[index][w][b];
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("%s.ready", tag), S_LINE'(ready), S_LINE'(m_ready));
      chk($sformatf("%s.rdata_valid", tag), S_LINE'(rdata_valid), S_LINE'(m_valid));
      for (int w = 0; w < NUM_WAYS; w++)
         chk($sformatf("%s.dataout_w%0d", tag, w), dataout[w*S_LINE +: S_LINE], m_dout[w*S_LINE +: S_LINE]);
   endtask

   task automatic rand_line();
      for (int k = 0; k < S_LINE/32; k++) datain[32*k +: 32] = $urandom;
   endtask

   initial begin
      int low_cnt;
      int vrun;

      rst = 1'b1; read = 1'b0; write_en = '0; write_way = '0; index = '0; datain = '0;
      m_ready = 1'b0; m_valid = 1'b0; m_sweep = 0; m_dout = '0;
      for (int s = 0; s < NUM_SETS; s++)
         for (int w = 0; w < NUM_WAYS; w++)
            for (int b = 0; b < S_MASK; b++)
               ref_mem[s][w][b] = 8'h00;

      // Reset, then count cycles with ready low.
      step("reset");
      chk("reset_dataout_zero", dataout[S_LINE-1:0], '0);
      rst = 1'b0;
      low_cnt = (ready === 1'b0) ? 1 : 0;
      for (int i = 0; i < 20 && ready !== 1'b1; i++) begin
         step("sweep1");
         if (ready === 1'b0) low_cnt++;
      end
      chk("ready_low_cycles", S_LINE'(low_cnt), S_LINE'(8));

      // Back-to-back reads of all indices: all zero, valid every cycle.
      vrun = 0;
      for (int i = 0; i < NUM_SETS; i++) begin
         read = 1'b1; index = S_INDEX'(i);
         step("read_zero");
         if (rdata_valid === 1'b1) vrun++;
         for (int w = 0; w < NUM_WAYS; w++)
            chk("zero_after_sweep", dataout[w*S_LINE +: S_LINE], '0);
      end
      read = 1'b0;
      step("read_stop");
      chk("valid_run_len", S_LINE'(vrun), S_LINE'(8));

      // Partial-byte write to way 2, index 5.
      write_en = 32'h0000_000F; write_way = 2'd2; index = 3'd5;
      datain = '0; datain[31:0] = 32'hDEADBEEF;
      step("wr_deadbeef");
      write_en = '0; read = 1'b1; datain = '1;
      step("rd_deadbeef");
      chk("deadbeef_way2", dataout[2*S_LINE +: S_LINE], {224'h0, 32'hDEADBEEF});
      chk("deadbeef_way0", dataout[0 +: S_LINE], '0);
      chk("deadbeef_way3", dataout[3*S_LINE +: S_LINE], '0);

      // Same-cycle read/write of one index: write-first.
      read = 1'b1; index = 3'd3; write_way = 2'd1; write_en = 32'h1;
      datain = '1; datain[7:0] = 8'hA5;
      step("wr_first");
      chk("write_first_byte0", S_LINE'(dataout[S_LINE +: 8]), S_LINE'(8'hA5));
      chk("write_first_byte1", S_LINE'(dataout[S_LINE+8 +: 8]), S_LINE'(8'h00));
      write_en = '0; read = 1'b0;
      step("idle_hold");

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         read      = 1'($urandom);
         write_en  = ($urandom_range(0, 3) == 0) ? '0 : S_MASK'($urandom);
         write_way = S_WAY'($urandom);
         index     = S_INDEX'($urandom);
         rand_line();
         step("random");
      end

      // Reset in IDLE with a live request, then requests during the sweep are ignored.
      read = 1'b1; write_en = '1; rand_line(); rst = 1'b1;
      step("rst_in_idle");
      rst = 1'b0;
      for (int i = 0; i < NUM_SETS; i++) begin
         index = S_INDEX'($urandom); write_way = S_WAY'($urandom); rand_line();
         step("req_not_ready");
         chk("valid_low_not_ready", S_LINE'(rdata_valid), S_LINE'(1'b0));
      end
      write_en = '0;
      for (int i = 0; i < NUM_SETS; i++) begin
         index = S_INDEX'(i);
         step("read_after_ignored");
         chk("ignored_reads_zero", dataout[S_LINE-1:0] | dataout[S_LINE +: S_LINE], '0);
      end
      read = 1'b0;

      // Fill every line, then restart the sweep midway.
      write_en = '1;
      for (int s = 0; s < NUM_SETS; s++)
         for (int w = 0; w < NUM_WAYS; w++) begin
            index = S_INDEX'(s); write_way = S_WAY'(w); rand_line();
            step("fill");
         end
      write_en = '0;
      rst = 1'b1;
      step("rst_fill");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step("sweep_partial");
      rst = 1'b1;
      step("rst_midsweep");
      rst = 1'b0;
      low_cnt = (ready === 1'b0) ? 1 : 0;
      for (int i = 0; i < 20 && ready !== 1'b1; i++) begin
         step("sweep2");
         if (ready === 1'b0) low_cnt++;
      end
      chk("ready_low_after_restart", S_LINE'(low_cnt), S_LINE'(8));
      read = 1'b1;
      for (int i = 0; i < NUM_SETS; i++) begin
         index = S_INDEX'(i);
         step("read_after_restart");
         for (int w = 0; w < NUM_WAYS; w++)
            chk("zero_after_restart", dataout[w*S_LINE +: S_LINE], '0);
      end
      read = 1'b0;
      step("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/l2_way_data_array.md
L2_WAY_DATA_ARRAY -- requirements
Module: l2_way_data_array

Interface
REQ-001 The block SHALL have parameter S_OFFSET, default 5, byte-offset bits; the line is 2**S_OFFSET bytes.
REQ-002 The block SHALL have parameter S_INDEX, default 3, index bits; NUM_SETS = 2**S_INDEX.
REQ-003 The block SHALL have parameter NUM_WAYS, default 4, associativity (power of two, >=2); S_WAY = log2(NUM_WAYS).
REQ-004 The block SHALL derive localparams S_MASK = 2**S_OFFSET and S_LINE = 8*S_MASK; these SHALL NOT be overridable.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be clk and rst.
REQ-006 Port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-007 Port rst, input, 1 bit: synchronous active-high reset.
REQ-008 Port read, input, 1 bit: read all ways at index this cycle.
REQ-009 Port write_en, input, S_MASK bits: per-byte write enables for way write_way.
REQ-010 Port write_way, input, S_WAY bits: target way of the write.
REQ-011 Port index, input, S_INDEX bits: set address shared by read and write.
REQ-012 Port datain, input, S_LINE bits: write line; byte i is datain[8i+7:8i].
REQ-013 Port dataout, output, NUM_WAYS*S_LINE bits: way w occupies slice [w*S_LINE +: S_LINE].
REQ-014 Port rdata_valid, output, 1 bit: dataout was updated by the read accepted in the previous cycle.
REQ-015 Port ready, output, 1 bit: array accepts read/write this cycle.

Function
REQ-016 The FSM SHALL have two states: CLEAR (zero-fill sweep) and IDLE (service requests).
REQ-017 In CLEAR, the block SHALL zero all NUM_WAYS lines of set clr_idx each cycle, then increment clr_idx.
REQ-018 CLEAR -> IDLE SHALL occur on the cycle clr_idx == NUM_SETS-1 is written; the sweep SHALL take exactly NUM_SETS cycles.
REQ-019 ready SHALL be 0 in CLEAR and 1 in IDLE; it SHALL be a registered output.
REQ-020 While ready == 0, read and write_en SHALL be ignored: no array change, and rdata_valid SHALL be 0 on the next cycle.
REQ-021 In IDLE with write_en != 0, each byte i with write_en[i] == 1 of way write_way at index SHALL take datain byte i at the edge; other bytes and ways SHALL be unchanged.
REQ-022 In IDLE with read == 1, dataout SHALL present all ways of set index one cycle later, and rdata_valid SHALL be 1 in that cycle.
REQ-023 When no read is accepted, dataout SHALL hold its last value and rdata_valid SHALL be 0 the next cycle.
REQ-024 On a read and write to the same index in the same cycle, the result SHALL be write-first: the enabled bytes of write_way SHALL show datain and all other bytes the prior contents.
REQ-025 A read and write to different indices in the same cycle SHALL both complete, with no interaction.
REQ-026 Back-to-back reads SHALL be supported every cycle at full throughput, with no bubbles.
REQ-027 write_en == 0 SHALL be a no-op regardless of write_way.
REQ-028 write_way SHALL be decoded exactly; out-of-range values cannot occur because NUM_WAYS is a power of two.

Reset
REQ-029 When rst == 1 at an edge, the state SHALL become CLEAR, clr_idx 0, ready 0, rdata_valid 0 and dataout all-zero.
REQ-030 A rst asserted mid-sweep SHALL restart the sweep from index 0.
REQ-031 A rst asserted in IDLE SHALL discard any same-cycle request, and a full zero-fill SHALL follow.
REQ-032 The array contents SHALL reach zero only through the sweep; no single-cycle bulk clear is required.

Verification
REQ-033 The bench SHALL cover this scenario: rst one cycle, then idle -> ready 0 for exactly 8 cycles (defaults), then 1; a read of every index in every way -> all zeros, rdata_valid 1 one cycle after each read.
REQ-034 The bench SHALL cover this scenario: write way 2, index 5, write_en 0x0000000F, datain bytes 0-3 = 0xDEADBEEF, then read index 5 -> way 2 bytes 0-3 = 0xDEADBEEF and all other bytes and ways 0.
REQ-035 The bench SHALL cover this scenario: same-cycle read and write of index 3, way 1, write_en 0x1, byte0 0xA5 -> the next-cycle dataout way 1 byte0 = 0xA5 (write-first).
REQ-036 The bench SHALL cover this scenario: read and write attempted while ready == 0 -> no array change, rdata_valid 0, and a later read returns 0.
REQ-037 The bench SHALL cover this scenario: fill all sets, assert rst at sweep cycle 4, release -> ready stays 0 for 8 further cycles, and all data then reads 0.
REQ-038 The bench SHALL cover this scenario: continuous reads of indices 0..7 -> rdata_valid held at 1 for 8 consecutive cycles, with correct data each cycle.
